// File: rtl/timer_tick_monitor.sv
// Receive-side checker for a periodic tick: measures edge-to-edge intervals,
// flags out-of-tolerance periods, tracks the worst interval and a sticky timeout.
module timer_tick_monitor #(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 10,
    parameter int TOL        = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    output logic             period_valid,
    output logic [CNT_W-1:0] period_out,
    output logic             in_range,
    output logic [CNT_W-1:0] period_max,
    output logic             timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    localparam logic signed [CNT_W:0] EXP_S = (CNT_W+1)'(EXP_PERIOD);
    localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);
    localparam logic [CNT_W-1:0]      TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               tick_d;
    logic               primed;
    logic               tick_edge;
    logic signed [CNT_W:0] diff;
    logic               cnt_in_range;

    // primed masks the first cycle after reset so a tick_in already high
    // at release is not mistaken for a rising edge.
    assign tick_edge = tick_in & ~tick_d & primed;

    // cnt is never above TIMEOUT, so the extra sign bit makes the subtraction exact.
    assign diff         = $signed({1'b0, cnt}) - EXP_S;
    assign cnt_in_range = (diff <= TOL_S) && (diff >= -TOL_S);

    // NOTE: every register here is assigned with <= so all updates use the
    // values from before the clock edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            tick_d       <= 1'b0;
            primed       <= 1'b0;
            period_valid <= 1'b0;
            period_out   <= '0;
            in_range     <= 1'b0;
            period_max   <= '0;
            timeout      <= 1'b0;
        end else begin
            tick_d       <= tick_in;
            primed       <= 1'b1;
            period_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick_edge) begin
                        cnt     <= CNT_W'(1);
                        timeout <= 1'b0;
                        state   <= MEAS;
                    end
                end
                MEAS: begin
                    if (tick_edge) begin
                        period_out   <= cnt;
                        period_valid <= 1'b1;
                        in_range     <= cnt_in_range;
                        if (cnt > period_max) period_max <= cnt;
                        cnt          <= CNT_W'(1);
                    end else if (cnt == TIMEOUT_C) begin
                        timeout <= 1'b1;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_tick_monitor.sv
// Self-checking bench for timer_tick_monitor: directed scenarios plus random
// pulse trains, all compared against an edge-timestamp reference model.
module tb_timer_tick_monitor;

    localparam int CNT_W      = 16;
    localparam int EXP_PERIOD = 10;
    localparam int TOL        = 1;
    localparam int TIMEOUT    = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             tick_in = 1'b0;
    logic             period_valid;
    logic [CNT_W-1:0] period_out;
    logic             in_range;
    logic [CNT_W-1:0] period_max;
    logic             timeout;

    int n_tests = 0;
    int n_fail  = 0;

    timer_tick_monitor #(
        .CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .TOL(TOL), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in),
        .period_valid(period_valid), .period_out(period_out), .in_range(in_range),
        .period_max(period_max), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model: remembers the cycle number of the last edge and derives
    // intervals and timeouts from timestamp differences.
    int               cyc = 0;
    int               m_last = 0;
    bit               m_meas, m_first, m_prev;
    logic             m_valid, m_inr, m_to;
    logic [CNT_W-1:0] m_period, m_max;

    initial begin
        m_meas = 0; m_first = 1; m_prev = 0;
        m_valid = 0; m_inr = 0; m_to = 0; m_period = '0; m_max = '0;
    end

    always @(posedge clk) begin
        bit e;
        int iv;
        cyc++;
        if (!rst) begin
            m_valid = 0; m_period = '0; m_inr = 0; m_max = '0; m_to = 0;
            m_meas = 0; m_first = 1; m_prev = 0;
        end else begin
            e       = tick_in && !m_prev && !m_first;
            m_first = 0;
            m_prev  = tick_in;
            m_valid = 0;
            if (m_meas && e) begin
                iv       = cyc - m_last;
                m_period = CNT_W'(iv);
                m_valid  = 1;
                m_inr    = (iv >= EXP_PERIOD - TOL) && (iv <= EXP_PERIOD + TOL);
                if (iv > int'(m_max)) m_max = CNT_W'(iv);
                m_last   = cyc;
            end else if (m_meas && (cyc - m_last) == TIMEOUT) begin
                m_to   = 1;
                m_meas = 0;
            end else if (!m_meas && e) begin
                m_meas = 1;
                m_last = cyc;
                m_to   = 0;
            end
        end
    end

    wire [2*CNT_W+2:0] obs  = {period_valid, period_out, in_range, period_max, timeout};
    wire [2*CNT_W+2:0] expv = {m_valid, m_period, m_inr, m_max, m_to};

    // Drive one cycle of stimulus and advance to just after the sampling edge.
    task automatic step(input logic t, input logic r = 1'b1);
        tick_in = t;
        rst     = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0);  // first post-reset cycle never counts as an edge
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(i[0], 1'b0);
            n_tests++;
            if (obs !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h expected 0", obs);
            end
        end
        step(1'b0);
        step(1'b1);
        n_tests++;
        if (period_valid !== 1'b0 || obs !== expv) begin
            n_fail++;
            $display("FAIL reset_first_edge: got %h expected %h", obs, expv);
        end
        step(1'b0);
    endtask

    task automatic test_nominal();
        int strobes = 0;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 10; c++) begin
                step(c == 0);
                n_tests++;
                if (obs !== expv) begin
                    n_fail++;
                    $display("FAIL nominal_model: got %h expected %h", obs, expv);
                end
                if (period_valid) begin
                    strobes++;
                    n_tests++;
                    if (c != 0 || period_out !== 16'd10 || in_range !== 1'b1 || period_max !== 16'd10) begin
                        n_fail++;
                        $display("FAIL nominal_strobe: c=%0d period=%0d in_range=%b max=%0d expected c=0 10/1/10",
                                 c, period_out, in_range, period_max);
                    end
                end
            end
        end
        n_tests++;
        if (strobes != 4) begin
            n_fail++;
            $display("FAIL nominal_count: got %0d strobes expected 4", strobes);
        end
    endtask

    task automatic test_intervals();
        int gaps[3] = '{12, 11, 9};
        logic [CNT_W-1:0] exp_p[3] = '{16'd12, 16'd11, 16'd9};
        logic             exp_r[3] = '{1'b0, 1'b1, 1'b1};
        int k = 0;
        do_reset();
        step(1'b1);
        step(1'b0);
        for (int g = 0; g < 3; g++) begin
            for (int c = 1; c < gaps[g]; c++) begin
                if (c > 1) step(1'b0);
            end
            step(1'b1);
            n_tests++;
            if (period_valid !== 1'b1 || period_out !== exp_p[k] || in_range !== exp_r[k] ||
                period_max !== 16'd12 || obs !== expv) begin
                n_fail++;
                $display("FAIL intervals_%0d: got valid=%b period=%0d in_range=%b max=%0d expected 1/%0d/%b/12",
                         k, period_valid, period_out, in_range, period_max, exp_p[k], exp_r[k]);
            end
            k++;
            step(1'b0);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        step(1'b1);
        for (int k = 1; k <= 70; k++) begin
            step(1'b0);
            n_tests++;
            if (period_valid !== 1'b0 || timeout !== (k >= 64) || obs !== expv) begin
                n_fail++;
                $display("FAIL timeout_k%0d: got valid=%b timeout=%b expected 0/%b", k, period_valid,
                         timeout, (k >= 64));
            end
        end
        step(1'b1);
        n_tests++;
        if (timeout !== 1'b0 || period_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: got timeout=%b valid=%b expected 0/0", timeout, period_valid);
        end
        for (int c = 1; c < 10; c++) step(1'b0);
        step(1'b1);
        n_tests++;
        if (period_valid !== 1'b1 || period_out !== 16'd10 || obs !== expv) begin
            n_fail++;
            $display("FAIL timeout_recover: got valid=%b period=%0d expected 1/10", period_valid, period_out);
        end
        step(1'b0);
    endtask

    task automatic test_held_high();
        int strobes = 0;
        do_reset();
        for (int c = 0; c < 36; c++) begin
            step(c < 30 || c == 35);
            if (period_valid) strobes++;
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL held_model: got %h expected %h", obs, expv);
            end
        end
        n_tests++;
        if (strobes != 1 || period_out !== 16'd35 || period_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL held_high: got %0d strobes period=%0d expected 1 strobe period=35", strobes, period_out);
        end
        step(1'b0);
    endtask

    task automatic test_mid_reset();
        do_reset();
        step(1'b1);
        for (int c = 1; c < 10; c++) step(1'b0);
        step(1'b1);  // valid period so outputs are nonzero before the reset
        for (int c = 1; c < 6; c++) step(1'b0);
        step(1'b0, 1'b0);
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL midreset_zero: got %h expected 0", obs);
        end
        step(1'b0);
        step(1'b0);
        step(1'b1);
        n_tests++;
        if (period_valid !== 1'b0 || obs !== expv) begin
            n_fail++;
            $display("FAIL midreset_first: got valid=%b expected 0", period_valid);
        end
        for (int c = 1; c < 10; c++) step(1'b0);
        step(1'b1);
        n_tests++;
        if (period_valid !== 1'b1 || period_out !== 16'd10 || in_range !== 1'b1 || obs !== expv) begin
            n_fail++;
            $display("FAIL midreset_follow: got valid=%b period=%0d expected 1/10", period_valid, period_out);
        end
        step(1'b0);
    endtask

    task automatic test_random();
        logic lvl = 1'b0;
        int   seg = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (seg == 0) begin
                lvl = ~lvl;
                seg = lvl ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 80));
            end
            seg--;
            step(lvl, ($urandom_range(0, 599) != 0));
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL random_c%0d: got %h expected %h", i, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_intervals();
        test_timeout();
        test_held_high();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
